// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage PC sequencer and its next-PC mux.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_ERROR = 2'd2
  } pc_state_t;

  localparam int unsigned PC_INCR    = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select: jump over branch over stall over sequential advance,
// with a misalignment flag on the chosen redirect target.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] i_pc,
  input  logic            i_stall,
  input  logic            i_jump,
  input  logic [SIZE-1:0] i_jump_target,
  input  logic            i_branch_taken,
  input  logic [SIZE-1:0] i_branch_target,
  output logic [SIZE-1:0] o_next_pc,
  output logic            o_redirect,
  output logic            o_misaligned
);

  logic [SIZE-1:0] w_target;

  always_comb begin
    w_target   = i_jump ? i_jump_target : i_branch_target;
    o_redirect = i_jump | i_branch_taken;
    if (o_redirect) begin
      o_next_pc = w_target;
    end else if (i_stall) begin
      o_next_pc = i_pc;
    end else begin
      o_next_pc = i_pc + SIZE'(PC_INCR);
    end
    o_misaligned = o_redirect && ((w_target[1:0] & ALIGN_MASK) != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: boot delay, PC register, IF/ID flush, sticky
// misaligned-redirect error and committed-fetch counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              SIZE        = 32,
  parameter logic [SIZE-1:0] RESET_PC    = '0,
  parameter int              BOOT_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_jump,
  input  logic [SIZE-1:0] i_jump_target,
  input  logic            i_branch_taken,
  input  logic [SIZE-1:0] i_branch_target,
  output logic [SIZE-1:0] o_pc,
  output logic            o_pc_valid,
  output logic            o_flush,
  output logic            o_error,
  output logic [31:0]     o_fetch_count
);

  pc_state_t       r_state, w_state_next;
  logic [3:0]      r_boot_cnt, w_boot_cnt_next;
  logic [SIZE-1:0] r_pc, w_pc_next;
  logic            r_pc_valid, w_pc_valid_next;
  logic            r_flush, w_flush_next;
  logic            r_error, w_error_next;
  logic [31:0]     r_fetch_count, w_fetch_count_next;

  logic [SIZE-1:0] w_mux_pc;
  logic            w_redirect;
  logic            w_misaligned;

  pc_next_mux #(.SIZE(SIZE)) u_next_mux (
    .i_pc            (r_pc),
    .i_stall         (i_stall),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .o_next_pc       (w_mux_pc),
    .o_redirect      (w_redirect),
    .o_misaligned    (w_misaligned)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_BOOT;
      r_boot_cnt    <= '0;
      r_pc          <= RESET_PC;
      r_pc_valid    <= 1'b0;
      r_flush       <= 1'b0;
      r_error       <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_boot_cnt    <= w_boot_cnt_next;
      r_pc          <= w_pc_next;
      r_pc_valid    <= w_pc_valid_next;
      r_flush       <= w_flush_next;
      r_error       <= w_error_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_boot_cnt_next    = r_boot_cnt;
    w_pc_next          = r_pc;
    w_pc_valid_next    = r_pc_valid;
    w_flush_next       = 1'b0;
    w_error_next       = r_error;
    w_fetch_count_next = r_fetch_count;

    case (r_state)
      S_BOOT: begin
        w_boot_cnt_next = r_boot_cnt + 4'd1;
        if (r_boot_cnt == 4'(BOOT_CYCLES - 1)) begin
          w_state_next    = S_RUN;
          w_pc_valid_next = 1'b1;
        end
      end
      S_RUN: begin
        if (w_misaligned) begin
          // Bad redirect: freeze the PC and stop fetching until reset.
          w_state_next    = S_ERROR;
          w_error_next    = 1'b1;
          w_pc_valid_next = 1'b0;
        end else begin
          w_pc_next    = w_mux_pc;
          w_flush_next = w_redirect;
          if (r_pc_valid && (w_redirect || !i_stall)) begin
            w_fetch_count_next = r_fetch_count + 32'd1;
          end
        end
      end
      default: begin
        w_state_next = S_ERROR;
      end
    endcase
  end

  assign o_pc          = r_pc;
  assign o_pc_valid    = r_pc_valid;
  assign o_flush       = r_flush;
  assign o_error       = r_error;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test of pc_sequencer: boot, stall, redirect priority, reset
// mid-redirect, misaligned target, plus an 8-bit instance for PC wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, jump, branch_taken;
  logic [31:0] jump_target, branch_target;
  logic [31:0] pc, fetch_count;
  logic        pc_valid, flush, error;

  logic [7:0]  z8_target = 8'h00;
  logic        z8_ctl = 1'b0;
  logic [7:0]  pc8;
  logic        pc8_valid, flush8, error8;
  logic [31:0] fetch_count8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.SIZE(32), .RESET_PC(32'h0), .BOOT_CYCLES(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_jump(jump),
    .i_jump_target(jump_target), .i_branch_taken(branch_taken),
    .i_branch_target(branch_target), .o_pc(pc), .o_pc_valid(pc_valid),
    .o_flush(flush), .o_error(error), .o_fetch_count(fetch_count)
  );

  pc_sequencer #(.SIZE(8), .RESET_PC(8'hF8), .BOOT_CYCLES(2)) dut8 (
    .i_clk(clk), .i_reset(reset), .i_stall(z8_ctl), .i_jump(z8_ctl),
    .i_jump_target(z8_target), .i_branch_taken(z8_ctl),
    .i_branch_target(z8_target), .o_pc(pc8), .o_pc_valid(pc8_valid),
    .o_flush(flush8), .o_error(error8), .o_fetch_count(fetch_count8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = 32'h0; branch_target = 32'h0;
  endtask

  // Expect pc / pc_valid / flush / fetch_count on the main instance.
  task automatic expect_run(input string tag, input logic [31:0] e_pc, input logic e_valid,
                            input logic e_flush, input logic [31:0] e_fc);
    check({tag, ".pc"}, 64'(pc), 64'(e_pc));
    check({tag, ".valid"}, 64'(pc_valid), 64'(e_valid));
    check({tag, ".flush"}, 64'(flush), 64'(e_flush));
    check({tag, ".fcnt"}, 64'(fetch_count), 64'(e_fc));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #3;
    expect_run("reset", 32'h0, 1'b0, 1'b0, 32'd0);
    check("reset.error", 64'(error), 64'd0);
    check("reset8.pc", 64'(pc8), 64'hF8);
    #97;
    reset = 1'b0;

    tick(); expect_run("boot0", 32'h0, 1'b0, 1'b0, 32'd0);
    tick(); expect_run("boot1", 32'h0, 1'b1, 1'b0, 32'd0);
    check("wrap.pc0", 64'(pc8), 64'hF8);
    check("wrap.valid", 64'(pc8_valid), 64'd1);
    tick(); expect_run("adv4", 32'h4, 1'b1, 1'b0, 32'd1);
    check("wrap.pc1", 64'(pc8), 64'hFC);
    tick(); expect_run("adv8", 32'h8, 1'b1, 1'b0, 32'd2);
    check("wrap.pc2", 64'(pc8), 64'h00);
    check("wrap.error", 64'(error8), 64'd0);
    tick(); expect_run("advC", 32'hC, 1'b1, 1'b0, 32'd3);
    tick(); expect_run("adv10", 32'h10, 1'b1, 1'b0, 32'd4);

    stall = 1'b1;
    tick(); expect_run("stall0", 32'h10, 1'b1, 1'b0, 32'd4);
    tick(); expect_run("stall1", 32'h10, 1'b1, 1'b0, 32'd4);
    stall = 1'b0;
    tick(); expect_run("unstall", 32'h14, 1'b1, 1'b0, 32'd5);

    stall = 1'b1; jump = 1'b1; jump_target = 32'h400;
    branch_taken = 1'b1; branch_target = 32'h200;
    tick(); expect_run("redir", 32'h400, 1'b1, 1'b1, 32'd6);
    idle_inputs();
    tick(); expect_run("redir+1", 32'h404, 1'b1, 1'b0, 32'd7);

    branch_taken = 1'b1; branch_target = 32'h40;
    tick(); expect_run("br40", 32'h40, 1'b1, 1'b1, 32'd8);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    expect_run("midrst", 32'h0, 1'b0, 1'b0, 32'd0);
    #2 reset = 1'b0;

    tick(); expect_run("reboot0", 32'h0, 1'b0, 1'b0, 32'd0);
    tick(); expect_run("reboot1", 32'h0, 1'b1, 1'b0, 32'd0);

    jump = 1'b1; jump_target = 32'h40;
    tick(); expect_run("j40", 32'h40, 1'b1, 1'b1, 32'd1);
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h102;
    tick(); expect_run("misal", 32'h40, 1'b0, 1'b0, 32'd1);
    check("misal.error", 64'(error), 64'd1);
    idle_inputs();
    jump = 1'b1; jump_target = 32'h80;
    tick(); expect_run("errj", 32'h40, 1'b0, 1'b0, 32'd1);
    check("errj.error", 64'(error), 64'd1);
    idle_inputs();
    tick(); expect_run("erridle", 32'h40, 1'b0, 1'b0, 32'd1);
    check("erridle.error", 64'(error), 64'd1);

    #2 reset = 1'b1;
    #1;
    check("errrst.error", 64'(error), 64'd0);
    check("errrst.pc", 64'(pc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
